// File: rtl/kernel_select_ctrl.sv
// Front-panel kernel selector: synchronises/debounces four active-low buttons, encodes the
// chosen filter and sequences the filter-processor reset window. Debounce gated by KSEL_DEBOUNCE_EN.
module kernel_select_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       kernel1,
  input  logic       kernel2,
  input  logic       kernel3,
  input  logic       identity,
  input  logic       proc_done,
  output logic [1:0] kernel,
  output logic       proc_reset,
  output logic       running,
  output logic       sel_pulse
);

  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

  localparam int unsigned NB  = 4;
  localparam int unsigned HCW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_bad_params
    $error("kernel_select_ctrl: DEBOUNCE_CYCLES must be >= 2 and HOLD_CYCLES >= 1");
  end

  state_t         state, state_nx;
  logic [HCW-1:0] hold_cnt;
  logic [NB-1:0]  btn_n, s1, s2, deb, deb_q, press;
  logic           accept;
  logic [1:0]     press_code;

  // Bit order follows selection priority: bit 0 (kernel1) wins.
  assign btn_n = {identity, kernel3, kernel2, kernel1};

  always_ff @(posedge CLK) begin
    if (reset) begin
      s1    <= '1;
      s2    <= '1;
      deb_q <= '1;
    end else begin
      s1    <= btn_n;
      s2    <= s1;
      deb_q <= deb;
    end
  end

`ifdef KSEL_DEBOUNCE_EN
  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

  logic [DCW-1:0] db_cnt [NB];
  logic [NB-1:0]  deb_r;

  always_ff @(posedge CLK) begin
    if (reset) begin
      deb_r <= '1;
      for (int unsigned i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (s2[i] == deb_r[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= DB_LAST) begin
          deb_r[i]  <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign deb = deb_r;
`else
  assign deb = s2;
`endif

  // Press = debounced falling edge; releases never generate events.
  assign press = deb_q & ~deb;

  always_comb begin
    press_code = 2'b00;
    if (press[0])      press_code = 2'b00;
    else if (press[1]) press_code = 2'b01;
    else if (press[2]) press_code = 2'b10;
    else if (press[3]) press_code = 2'b11;
    accept = (|press) && !(state == RUN && press_code == kernel);
  end

  always_comb begin
    state_nx = state;
    case (state)
      HOLD: begin
        if (accept)                     state_nx = HOLD;
        else if (hold_cnt == HOLD_LAST) state_nx = RUN;
      end
      RUN: begin
        if (accept)         state_nx = HOLD;
        else if (proc_done) state_nx = DONE;
      end
      DONE: begin
        if (accept) state_nx = HOLD;
      end
      default: state_nx = HOLD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      kernel     <= 2'b00;
      sel_pulse  <= 1'b0;
      proc_reset <= 1'b1;
      running    <= 1'b0;
    end else begin
      state      <= state_nx;
      sel_pulse  <= accept;
      proc_reset <= (state_nx == HOLD);
      running    <= (state_nx == RUN);
      if (accept) begin
        kernel   <= press_code;
        hold_cnt <= '0;
      end else if (state == HOLD && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kernel_select_ctrl.sv
// Self-checking bench for kernel_select_ctrl: cycle-tagged expectations queued by the stimulus
// thread and compared by a monitor #1 after each rising edge.
module tb_kernel_select_ctrl;

`ifdef KSEL_DEBOUNCE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       kernel1 = 1'b1, kernel2 = 1'b1, kernel3 = 1'b1, identity = 1'b1;
  logic       proc_done = 1'b0;
  logic [1:0] kernel;
  logic       proc_reset, running, sel_pulse;

  kernel_select_ctrl #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(3)) dut (
    .CLK(CLK), .reset(reset), .kernel1(kernel1), .kernel2(kernel2), .kernel3(kernel3),
    .identity(identity), .proc_done(proc_done), .kernel(kernel), .proc_reset(proc_reset),
    .running(running), .sel_pulse(sel_pulse)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [1:0] k;
    logic       pr, run, sp;
    string      name;
  } exp_t;

  typedef struct {
    logic       rst, done;
    logic [3:0] btn;   // {identity, kernel3, kernel2, kernel1}
    logic [1:0] k;
    logic       pr, run, sp;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl [7];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) begin
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if ({kernel, proc_reset, running, sel_pulse} !== {e.k, e.pr, e.run, e.sp}) begin
        errors++;
        $display("FAIL %s cyc=%0d got k=%b pr=%b run=%b sp=%b expected k=%b pr=%b run=%b sp=%b",
                 e.name, cyc, kernel, proc_reset, running, sel_pulse, e.k, e.pr, e.run, e.sp);
      end
    end
  end

  task automatic push(input int c, input logic [1:0] k, input logic pr, input logic run,
                      input logic sp, input string name);
    exp_t x;
    x.cyc = c; x.k = k; x.pr = pr; x.run = run; x.sp = sp; x.name = name;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int b, ev;
    //          rst   done  btn      k      pr    run   sp
    tbl[0] = '{1'b1, 1'b0, 4'hF, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 4'hF, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 4'hF, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 4'hF, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0};

    tick(3);
    for (int i = 0; i < 7; i++) begin
      reset = tbl[i].rst;
      proc_done = tbl[i].done;
      {identity, kernel3, kernel2, kernel1} = tbl[i].btn;
      push(cyc + 1, tbl[i].k, tbl[i].pr, tbl[i].run, tbl[i].sp, $sformatf("tbl%0d", i));
      tick(1);
    end

    // kernel3 held: one event, full hold window, no repeat while held or on release
    b = cyc; ev = b + 3 + LAT;
    kernel3 = 1'b0;
    push(ev - 1, 2'b00, 1'b0, 1'b0, 1'b0, "k3_pre");
    push(ev,     2'b10, 1'b1, 1'b0, 1'b1, "k3_sel");
    push(ev + 1, 2'b10, 1'b1, 1'b0, 1'b0, "k3_hold2");
    push(ev + 2, 2'b10, 1'b1, 1'b0, 1'b0, "k3_hold3");
    push(ev + 3, 2'b10, 1'b0, 1'b1, 1'b0, "k3_run");
    push(ev + 8, 2'b10, 1'b0, 1'b1, 1'b0, "k3_held");
    tick(ev + 8 - b);
    kernel3 = 1'b1;
    push(cyc + LAT + 4, 2'b10, 1'b0, 1'b1, 1'b0, "k3_release");
    tick(LAT + 4);

`ifdef KSEL_DEBOUNCE_EN
    // three-cycle glitch on kernel2 is filtered out
    b = cyc;
    push(b + 3, 2'b10, 1'b0, 1'b1, 1'b0, "glitch_mid");
    push(b + 7, 2'b10, 1'b0, 1'b1, 1'b0, "glitch_nosel");
    push(b + 8, 2'b10, 1'b0, 1'b1, 1'b0, "glitch_after");
    kernel2 = 1'b0;
    tick(3);
    kernel2 = 1'b1;
    tick(5);
`endif

    // kernel1 and identity together: kernel1 wins, single pulse
    b = cyc; ev = b + 3 + LAT;
    kernel1 = 1'b0; identity = 1'b0;
    push(ev,     2'b00, 1'b1, 1'b0, 1'b1, "dual_sel");
    push(ev + 1, 2'b00, 1'b1, 1'b0, 1'b0, "dual_one_pulse");
    push(ev + 3, 2'b00, 1'b0, 1'b1, 1'b0, "dual_run");
    tick(ev + 3 - b);
    kernel1 = 1'b1; identity = 1'b1;
    tick(LAT + 4);

    // select kernel2, then re-press it in RUN (ignored)
    b = cyc; ev = b + 3 + LAT;
    kernel2 = 1'b0;
    push(ev,     2'b01, 1'b1, 1'b0, 1'b1, "k2_sel");
    push(ev + 3, 2'b01, 1'b0, 1'b1, 1'b0, "k2_run");
    tick(ev + 3 - b);
    kernel2 = 1'b1;
    tick(LAT + 4);
    b = cyc; ev = b + 3 + LAT;
    kernel2 = 1'b0;
    push(ev,     2'b01, 1'b0, 1'b1, 1'b0, "k2_same_ignored");
    push(ev + 1, 2'b01, 1'b0, 1'b1, 1'b0, "k2_same_still_run");
    tick(ev + 1 - b);
    kernel2 = 1'b1;
    tick(LAT + 4);

    // identity, then kernel1 one cycle later lands in HOLD and restarts the window
    b = cyc; ev = b + 3 + LAT;
    identity = 1'b0;
    push(ev,     2'b11, 1'b1, 1'b0, 1'b1, "id_sel");
    push(ev + 1, 2'b00, 1'b1, 1'b0, 1'b1, "k1_in_hold");
    push(ev + 2, 2'b00, 1'b1, 1'b0, 1'b0, "restart_hold2");
    push(ev + 3, 2'b00, 1'b1, 1'b0, 1'b0, "restart_hold3");
    push(ev + 4, 2'b00, 1'b0, 1'b1, 1'b0, "restart_run");
    tick(1);
    kernel1 = 1'b0;
    tick(ev + 4 - (b + 1));
    kernel1 = 1'b1; identity = 1'b1;
    tick(LAT + 4);

    // reset in the middle of a hold window starts a fresh one
    b = cyc; ev = b + 3 + LAT;
    identity = 1'b0;
    push(ev, 2'b11, 1'b1, 1'b0, 1'b1, "id2_sel");
    tick(ev - b);
    identity = 1'b1;
    reset = 1'b1;
    push(ev + 1, 2'b00, 1'b1, 1'b0, 1'b0, "rst_mid_hold");
    push(ev + 2, 2'b00, 1'b1, 1'b0, 1'b0, "rst_hold2");
    push(ev + 3, 2'b00, 1'b1, 1'b0, 1'b0, "rst_hold3");
    push(ev + 4, 2'b00, 1'b0, 1'b1, 1'b0, "rst_run");
    push(ev + 8 + LAT, 2'b00, 1'b0, 1'b1, 1'b0, "rst_settled");
    tick(1);
    reset = 1'b0;
    tick(7 + LAT);

    tick(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_select_ctrl.md
# kernel_select_ctrl

Front-panel controller upstream of the instruction memory and filter processor in the Filter-GPU top level. It synchronises and debounces the four active-low push buttons (kernel1, kernel2, kernel3, identity) and encodes the chosen filter into the 2-bit kernel code that selects the instruction-memory program. On every accepted selection it holds the filter processor in reset for a fixed window so execution restarts from PC 0, then tracks run/done status.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz); minimum 2.
- HOLD_CYCLES, 16: cycles proc_reset is held high per restart; minimum 1.
- CLK  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- kernel1  in  1  asynchronous button, active-low; selects code 2'b00.
- kernel2  in  1  asynchronous button, active-low; selects code 2'b01.
- kernel3  in  1  asynchronous button, active-low; selects code 2'b10.
- identity  in  1  asynchronous button, active-low; selects code 2'b11.
- proc_done  in  1  level from filter processor; high once the program has finished.
- kernel  out  2  current kernel code to instruction memory.
- proc_reset  out  1  active-high reset to filter processor.
- running  out  1  high while the processor executes (state RUN).
- sel_pulse  out  1  one-cycle strobe on every accepted selection.

## Operation
- Per button: 2-flop synchroniser (s1, s2), then debounce filter. The debounced level deb takes s2 only after s2 differs from deb for DEBOUNCE_CYCLES consecutive cycles. Any return of s2 to deb clears the counter. Counter width is $clog2(DEBOUNCE_CYCLES)+1; it saturates and never wraps.
- Press event: deb transitions 1→0. Release events are ignored. Holding a button produces exactly one event.
- Simultaneous events in the same cycle: priority kernel1 > kernel2 > kernel3 > identity. Lower-priority events in that cycle are discarded.
- FSM states: HOLD, RUN, DONE.
  - HOLD: proc_reset=1, running=0. The hold counter counts HOLD_CYCLES cycles, then the FSM moves to RUN.
  - RUN: proc_reset=0, running=1. proc_done=1 moves the FSM to DONE.
  - DONE: proc_reset=0, running=0. It stays there until a press event arrives.
- Accepted press in any state:
  - kernel ← the pressed code.
  - sel_pulse=1 for one cycle.
  - The FSM enters HOLD with the hold counter reloaded. A press during HOLD restarts the full hold window.
- Exception: in RUN, a press whose code equals the current kernel is ignored. There is no pulse and no restart.
- proc_done is ignored in HOLD and DONE.
- reset sets:
  - state=HOLD, kernel=2'b00, proc_reset=1, running=0, sel_pulse=0.
  - All debounce and hold counters to 0.
  - s1, s2 and deb to 1 (released).
- Reset mid-operation aborts any pending debounce and any hold window, and starts a fresh HOLD of HOLD_CYCLES.

## Timing
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Debounce latency: a button is low from before edge 1 and stays low. s2 goes low at edge 2, deb goes low at edge 2+DEBOUNCE_CYCLES, and kernel, sel_pulse and the entry into HOLD update at edge 3+DEBOUNCE_CYCLES.
- A low glitch of DEBOUNCE_CYCLES−1 or fewer cycles at s2 is rejected.
- proc_reset is high for exactly HOLD_CYCLES cycles after HOLD entry. running rises on the same edge that proc_reset falls.
- A proc_done high sampled at edge n in RUN drops running at edge n (the state changes that edge).

## Configuration
- KSEL_DEBOUNCE_EN defined: the debounce filter is present as described.
- KSEL_DEBOUNCE_EN undefined: deb = s2 directly, DEBOUNCE_CYCLES is unused, and the kernel update lands at edge 3. This build is for fast simulation only.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=3, with KSEL_DEBOUNCE_EN defined unless stated.
- Reset release: kernel=00 and proc_reset=1 for 3 cycles, then running=1. With proc_done=1, the FSM reaches DONE and running=0.
- kernel3 low from edge 1, held: at edge 7, kernel=10, sel_pulse=1 for one cycle and proc_reset=1 for 3 cycles. No second event while the button stays held.
- kernel2 low glitch of 3 cycles at s2: no change to kernel, sel_pulse or state.
- kernel1 and identity debounced in the same cycle: kernel=00, one sel_pulse.
- In RUN with kernel=01, press kernel2 → ignored. Press identity → kernel=11 and HOLD. Press kernel1 during that HOLD → kernel=00 and a full 3-cycle hold restarts.
- KSEL_DEBOUNCE_EN undefined: identity low from edge 1 gives kernel=11 at edge 3. Assert reset mid-HOLD → kernel=00 and a fresh 3-cycle proc_reset.
